// File: rtl/exu_lsu_if.sv
// AGU-side request/completion and data-bus command/response signals of the
// load/store unit, bundled so the unit and its environment share one port.
interface exu_lsu_if;
    // AGU request / completion
    logic        hs_ag4ls_val;
    logic        hs_ls4ag_rdy;
    logic [31:0] i_ls_adr;
    logic [31:0] i_ls_wdat;
    logic [3:0]  i_ls_wen;
    logic        i_ls_ren;
    logic [31:0] o_ls_rdat;
    logic        o_ls_err;
    // Data bus command channel
    logic        o_bus_cmd_val;
    logic        i_bus_cmd_rdy;
    logic [31:0] o_bus_cmd_adr;
    logic        o_bus_cmd_read;
    logic [31:0] o_bus_cmd_wdat;
    logic [3:0]  o_bus_cmd_wen;
    // Data bus response channel
    logic        i_bus_rsp_val;
    logic        o_bus_rsp_rdy;
    logic [31:0] i_bus_rsp_rdat;
    logic        i_bus_rsp_err;

    // Load/store unit view
    modport master (
        input  hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        input  i_bus_cmd_rdy, i_bus_rsp_val, i_bus_rsp_rdat, i_bus_rsp_err,
        output hs_ls4ag_rdy, o_ls_rdat, o_ls_err,
        output o_bus_cmd_val, o_bus_cmd_adr, o_bus_cmd_read, o_bus_cmd_wdat, o_bus_cmd_wen,
        output o_bus_rsp_rdy
    );

    // Environment view (AGU plus data bus)
    modport slave (
        output hs_ag4ls_val, i_ls_adr, i_ls_wdat, i_ls_wen, i_ls_ren,
        output i_bus_cmd_rdy, i_bus_rsp_val, i_bus_rsp_rdat, i_bus_rsp_err,
        input  hs_ls4ag_rdy, o_ls_rdat, o_ls_err,
        input  o_bus_cmd_val, o_bus_cmd_adr, o_bus_cmd_read, o_bus_cmd_wdat, o_bus_cmd_wen,
        input  o_bus_rsp_rdy
    );
endinterface

// File: rtl/exu_lsu.sv
// Load/store unit behind the EXU address-generation stage.
// One access at a time: latch the request in IDLE, issue it on the bus (CMD),
// wait for the response (RSP), then pulse completion for one cycle (DONE).
//
// Handshakes: the bus command transfers in a cycle where o_bus_cmd_val and
// i_bus_cmd_rdy are both 1; the response transfers in a cycle where
// i_bus_rsp_val and o_bus_rsp_rdy are both 1. The AGU holds hs_ag4ls_val
// until it sees the one-cycle hs_ls4ag_rdy pulse; the request is only
// sampled in IDLE.
//
// A watchdog counts cycles spent in CMD+RSP. When the count reaches
// 2^TMO_W-1 without a transfer in that cycle, the access ends with err=1.
// A transfer that does happen in that same cycle is honoured, because the
// bus has already seen it complete; after a last-cycle command acceptance
// the response gets one more cycle before the access is abandoned.
module exu_lsu #(
    parameter int TMO_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    exu_lsu_if.master  ls,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;
    localparam logic [TMO_W-1:0] TMO_PRE = TMO_MAX - TMO_W'(1);

    state_t           state;
    state_t           state_nxt;

    logic [29:0]      adr_q;
    logic [31:0]      wdat_q;
    logic [3:0]       wen_q;
    logic             rd_q;
    logic [31:0]      rdat_q;
    logic             err_q;
    logic [TMO_W-1:0] cnt_q;

    logic             cmd_val;
    logic             rsp_rdy;
    logic             ld_req;
    logic             cap_rsp;
    logic             set_tmo;
    logic             tmo_hit;

    // Watchdog expires on the cycle that brings the count to its last value.
    assign tmo_hit = (cnt_q >= TMO_PRE);

    // State register; reset drops bus valid/ready immediately via the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake control.
    always_comb begin
        state_nxt = state;
        cmd_val   = 1'b0;
        rsp_rdy   = 1'b0;
        ld_req    = 1'b0;
        cap_rsp   = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (ls.hs_ag4ls_val) begin
                    ld_req = 1'b1;
                    // Writes win over reads; neither enable set is a null access.
                    if ((ls.i_ls_wen != 4'd0) || ls.i_ls_ren) begin
                        state_nxt = CMD;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CMD: begin
                cmd_val = 1'b1;
                if (ls.i_bus_cmd_rdy) begin
                    state_nxt = RSP;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    state_nxt = DONE;
                end
            end
            RSP: begin
                rsp_rdy = 1'b1;
                if (ls.i_bus_rsp_val) begin
                    cap_rsp   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, result capture and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q  <= '0;
            wdat_q <= '0;
            wen_q  <= '0;
            rd_q   <= 1'b0;
            rdat_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (ld_req) begin
                adr_q  <= ls.i_ls_adr[31:2];
                wdat_q <= ls.i_ls_wdat;
                wen_q  <= ls.i_ls_wen;
                rd_q   <= (ls.i_ls_wen == 4'd0) && ls.i_ls_ren;
                rdat_q <= '0;
                err_q  <= 1'b0;
                cnt_q  <= '0;
            end else if ((state == CMD) || (state == RSP)) begin
                if (cnt_q != TMO_MAX) begin
                    cnt_q <= cnt_q + TMO_W'(1);
                end
            end
            if (cap_rsp) begin
                rdat_q <= rd_q ? ls.i_bus_rsp_rdat : 32'd0;
                err_q  <= ls.i_bus_rsp_err;
            end else if (set_tmo) begin
                rdat_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    // Bus and AGU outputs; results are visible only during the completion pulse.
    always_comb begin
        ls.o_bus_cmd_val  = cmd_val;
        ls.o_bus_cmd_adr  = {adr_q, 2'b00};
        ls.o_bus_cmd_read = rd_q;
        ls.o_bus_cmd_wdat = wdat_q;
        ls.o_bus_cmd_wen  = wen_q;
        ls.o_bus_rsp_rdy  = rsp_rdy;
        ls.hs_ls4ag_rdy   = (state == DONE);
        ls.o_ls_rdat      = (state == DONE) ? rdat_q : 32'd0;
        ls.o_ls_err       = (state == DONE) ? err_q : 1'b0;
        dbg_state         = state;
    end

endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu: directed cases plus randomized accesses against a
// cycle-count reference model; a monitor pops expected results on every
// completion pulse.
module tb_exu_lsu;

    localparam int TMO_W = 3;
    localparam int MAXC  = (1 << TMO_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    exu_lsu_if bus_if ();

    exu_lsu #(.TMO_W(TMO_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ls        (bus_if),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cmd_hs = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: command handshake count and completion scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.o_bus_cmd_val && bus_if.i_bus_cmd_rdy) cmd_hs++;
            if (bus_if.hs_ls4ag_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy actual=1 required=0 at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ls_rdat", bus_if.o_ls_rdat, mon_e[31:0]);
                    check("ls_err", 32'(bus_if.o_ls_err), 32'(mon_e[32]));
                end
            end else begin
                check("ls_out_quiet", bus_if.o_ls_rdat | 32'(bus_if.o_ls_err), 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        bus_if.hs_ag4ls_val   = 1'b0;
        bus_if.i_ls_adr       = '0;
        bus_if.i_ls_wdat      = '0;
        bus_if.i_ls_wen       = '0;
        bus_if.i_ls_ren       = 1'b0;
        bus_if.i_bus_cmd_rdy  = 1'b0;
        bus_if.i_bus_rsp_val  = 1'b0;
        bus_if.i_bus_rsp_rdat = '0;
        bus_if.i_bus_rsp_err  = 1'b0;
    endtask

    // One access. The bus accepts the command in busy cycle w+1 and returns
    // its response d cycles later; spur adds stray responses before that.
    task automatic do_access(input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] wen, input logic ren,
                             input int w, input int d,
                             input logic [31:0] prdat, input logic perr, input bit spur);
        int          a, r, lim, lat, ncmd, hs0;
        logic [31:0] erdat;
        logic        eerr;
        bit          is_null, is_rd, done;
        is_null = (wen == 4'd0) && !ren;
        is_rd   = (wen == 4'd0);
        a       = w + 1;
        // Reference model: result and completion cycle from the bus timing.
        if (is_null) begin
            lat = 1; erdat = 32'd0; eerr = 1'b0; ncmd = 0;
        end else if (a > MAXC) begin
            lat = MAXC + 1; erdat = 32'd0; eerr = 1'b1; ncmd = 0;
        end else begin
            r    = a + d;
            lim  = (a + 1 > MAXC) ? a + 1 : MAXC;
            ncmd = 1;
            if (r <= lim) begin
                lat = r + 1; erdat = is_rd ? prdat : 32'd0; eerr = perr;
            end else begin
                lat = lim + 1; erdat = 32'd0; eerr = 1'b1;
            end
        end
        exp_q.push_back({eerr, erdat});

        @(posedge clk); #2;
        hs0 = cmd_hs;
        bus_if.hs_ag4ls_val = 1'b1;
        bus_if.i_ls_adr     = adr;
        bus_if.i_ls_wdat    = wdat;
        bus_if.i_ls_wen     = wen;
        bus_if.i_ls_ren     = ren;
        bus_if.i_bus_cmd_rdy = 1'b0;
        bus_if.i_bus_rsp_val = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #2;
            if (bus_if.hs_ls4ag_rdy) begin
                check("rdy_latency", 32'(k), 32'(lat));
                check("rdy_bus_idle", 32'({bus_if.o_bus_cmd_val, bus_if.o_bus_rsp_rdy}), 32'd0);
                idle_inputs();
                done = 1'b1;
            end else begin
                if (!is_null && k <= a && k <= MAXC) begin
                    check("cmd_val", 32'(bus_if.o_bus_cmd_val), 32'd1);
                    check("cmd_adr", bus_if.o_bus_cmd_adr, {adr[31:2], 2'b00});
                    check("cmd_read", 32'(bus_if.o_bus_cmd_read), 32'(is_rd));
                    check("cmd_wen", 32'(bus_if.o_bus_cmd_wen), is_rd ? 32'd0 : 32'(wen));
                    if (!is_rd) check("cmd_wdat", bus_if.o_bus_cmd_wdat, wdat);
                end
                bus_if.i_bus_cmd_rdy = (k == a);
                if (!is_null && k == a + d) begin
                    bus_if.i_bus_rsp_val  = 1'b1;
                    bus_if.i_bus_rsp_rdat = prdat;
                    bus_if.i_bus_rsp_err  = perr;
                end else if (spur && k <= a && $urandom_range(0, 1) == 1) begin
                    bus_if.i_bus_rsp_val  = 1'b1;
                    bus_if.i_bus_rsp_rdat = $urandom;
                    bus_if.i_bus_rsp_err  = 1'($urandom_range(0, 1));
                end else begin
                    bus_if.i_bus_rsp_val  = 1'b0;
                    bus_if.i_bus_rsp_rdat = $urandom;
                    bus_if.i_bus_rsp_err  = 1'b0;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rdy_wait actual=none required=cycle_%0d", lat);
            idle_inputs();
            void'(exp_q.pop_back());
        end
        check("cmd_count", 32'(cmd_hs - hs0), 32'(ncmd));
    endtask

    // Reset asserted while the unit waits for a read response.
    task automatic reset_mid_rsp();
        @(posedge clk); #2;
        bus_if.hs_ag4ls_val = 1'b1;
        bus_if.i_ls_adr     = 32'h0000_0400;
        bus_if.i_ls_ren     = 1'b1;
        @(posedge clk); #2;
        bus_if.i_bus_cmd_rdy = 1'b1;
        @(posedge clk); #2;
        bus_if.i_bus_cmd_rdy = 1'b0;
        check("rst_pre_rsp_rdy", 32'(bus_if.o_bus_rsp_rdy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_rsp_rdy", 32'(bus_if.o_bus_rsp_rdy), 32'd0);
        check("rst_async_cmd_val", 32'(bus_if.o_bus_cmd_val), 32'd0);
        check("rst_async_rdy", 32'(bus_if.hs_ls4ag_rdy), 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Reset, directed cases, random traffic, report.
    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_rdy", 32'(bus_if.hs_ls4ag_rdy), 32'd0);
        check("reset_cmd_val", 32'(bus_if.o_bus_cmd_val), 32'd0);
        check("reset_rsp_rdy", 32'(bus_if.o_bus_rsp_rdy), 32'd0);
        check("reset_cmd_adr", bus_if.o_bus_cmd_adr, 32'd0);
        check("reset_ls_rdat", bus_if.o_ls_rdat, 32'd0);
        rst = 1'b0;

        // Zero-wait read
        do_access(32'h0000_1006, 32'h0, 4'h0, 1'b1, 0, 2, 32'hA5B6_C7D8, 1'b0, 1'b0);
        // Byte write with three cycles of command backpressure
        do_access(32'h0000_0020, 32'h00EE_0000, 4'b0100, 1'b0, 3, 1, 32'h1234_5678, 1'b0, 1'b0);
        // Bus error on a read
        do_access(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        // Command never accepted
        do_access(32'h0000_0200, 32'h0, 4'h0, 1'b1, 30, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Null access followed immediately by a read
        do_access(32'h0000_0300, 32'hCAFE_0000, 4'h0, 1'b0, 0, 1, 32'h0, 1'b0, 1'b0);
        do_access(32'h0000_0304, 32'h0, 4'h0, 1'b1, 0, 1, 32'h0BAD_F00D, 1'b0, 1'b1);
        // Write wins over read when both are requested
        do_access(32'h0000_0044, 32'h1122_3344, 4'b1111, 1'b1, 1, 2, 32'h5555_AAAA, 1'b0, 1'b1);
        // Response arrives after the watchdog expires
        do_access(32'h0000_0048, 32'h0, 4'h0, 1'b1, 1, 9, 32'h7777_7777, 1'b0, 1'b0);
        // Reset mid-response, then a normal access
        reset_mid_rsp();
        do_access(32'h0000_0500, 32'h0, 4'h0, 1'b1, 0, 1, 32'h1357_9BDF, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            logic [3:0] wen;
            int         w;
            int         d;
            wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            w   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 3));
            d   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(1, 3));
            do_access($urandom, $urandom, wen, 1'($urandom_range(0, 1)), w, d,
                      $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
